// File: rtl/result_display_pkg.sv
// result_display_pkg
//   Shared definitions for the result display block: controller state
//   encoding, BCD width, active-low 7-segment patterns ({g,f,e,d,c,b,a})
//   and the double-dabble nibble adjust helper.
package result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a nibble of 5 or more would carry past 9
    // after the next shift, so pre-add 3.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/result_display_seg7_decode.sv
// seg7_decode
//   Combinational nibble to active-low 7-segment pattern.
//   Ports:
//     nib    - BCD digit to show
//     blank  - force all segments off
//     show_e - show "E" (wins over blank and nib)
//     seg    - {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       show_e,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (show_e) begin
            seg = SEG_E;
        end else if (!blank) begin
            case (nib)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// result_display
//   Captures the multiplier product and overflow flag, converts the product
//   to three BCD digits with a one-shift-per-clock double-dabble, and scans
//   a 4-digit active-low 7-segment display (digit 3 shows "E" on overflow).
//   Ports:
//     CK   - clock, rising edge
//     RST  - synchronous reset, active-high
//     S    - product to capture
//     OV   - overflow flag to capture
//     VLD  - capture strobe, honoured in IDLE/DONE only
//     BUSY - conversion running
//     RDY  - BCD holds the last captured result
//     BCD  - {hundreds, tens, units}
//     DIG  - digit select, active-low one-cold
//     SEG  - segments {g,f,e,d,c,b,a}, active-low
module result_display
    import result_display_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [7:0]       S,
    input  logic             OV,
    input  logic             VLD,
    output logic             BUSY,
    output logic             RDY,
    output logic [BCD_W-1:0] BCD,
    output logic [3:0]       DIG,
    output logic [6:0]       SEG
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state, state_nxt;
    logic               capture, step, finish;
    logic [7:0]         sr;
    logic [BCD_W-1:0]   work;
    logic [2:0]         iter;
    logic               ov_q;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W+7:0]   shifted;

    // ---------------- controller ----------------
    always_ff @(posedge CK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (VLD) begin
                    capture   = 1'b1;
                    state_nxt = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                step = 1'b1;
                if (iter == 3'd7) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    assign adj     = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};
    assign shifted = {adj, sr} << 1;

    always_ff @(posedge CK) begin
        if (RST) begin
            sr   <= '0;
            work <= '0;
            iter <= '0;
            ov_q <= 1'b0;
            BCD  <= '0;
            BUSY <= 1'b0;
            RDY  <= 1'b0;
        end else if (capture) begin
            sr   <= S;
            work <= '0;
            iter <= '0;
            ov_q <= OV;
            BUSY <= 1'b1;
            RDY  <= 1'b0;
        end else if (step) begin
            work <= shifted[BCD_W+7:8];
            sr   <= shifted[7:0];
            iter <= iter + 3'd1;
            if (finish) begin
                // The shifted value is the finished result; take it
                // directly so BCD lands on the same edge as the last shift.
                BCD  <= shifted[BCD_W+7:8];
                BUSY <= 1'b0;
                RDY  <= 1'b1;
            end
        end
    end

    // ---------------- display scan ----------------
    logic [CW-1:0] scan_cnt;
    logic [1:0]    dig_idx;
    logic [3:0]    nib;
    logic          blank, show_e;
    logic [6:0]    seg_c;

    always_ff @(posedge CK) begin
        if (RST) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    always_comb begin
        nib    = 4'd0;
        blank  = 1'b0;
        show_e = 1'b0;
        case (dig_idx)
            2'd0: nib = BCD[3:0];
            2'd1: begin
                nib   = BCD[7:4];
                blank = (BCD[11:8] == 4'd0) && (BCD[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = BCD[11:8];
                blank = (BCD[11:8] == 4'd0);
            end
            default: begin
                blank  = !ov_q;
                show_e = ov_q;
            end
        endcase
    end

    seg7_decode u_dec (
        .nib    (nib),
        .blank  (blank),
        .show_e (show_e),
        .seg    (seg_c)
    );

    // DIG and SEG come from the same registered index so they never skew.
    always_ff @(posedge CK) begin
        if (RST) begin
            DIG <= 4'b1110;
            SEG <= SEG_0;
        end else begin
            DIG <= ~(4'b0001 << dig_idx);
            SEG <= seg_c;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb_result_display
//   Directed bench for result_display: reset values, scan timing at
//   SCAN_DIV=4 and SCAN_DIV=1, conversions with digit content, VLD ignore
//   during conversion and mid-conversion reset.
module tb_result_display;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  S = '0;
    logic        OV = 1'b0;
    logic        VLD = 1'b0;
    logic        BUSY, RDY, BUSY1, RDY1;
    logic [11:0] BCD, BCD1;
    logic [3:0]  DIG, DIG1;
    logic [6:0]  SEG, SEG1;

    int checks = 0;
    int failures = 0;

    always #5 CK = ~CK;

    result_display #(.SCAN_DIV(4)) dut (
        .CK(CK), .RST(RST), .S(S), .OV(OV), .VLD(VLD),
        .BUSY(BUSY), .RDY(RDY), .BCD(BCD), .DIG(DIG), .SEG(SEG)
    );

    result_display #(.SCAN_DIV(1)) dut1 (
        .CK(CK), .RST(RST), .S(S), .OV(OV), .VLD(VLD),
        .BUSY(BUSY1), .RDY(RDY1), .BCD(BCD1), .DIG(DIG1), .SEG(SEG1)
    );

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for digit k to be selected, then check its pattern.
    task automatic chk_digit(input int k, input logic [6:0] exp, input string tag);
        logic [3:0] want;
        logic found;
        want  = ~(4'b0001 << k);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (DIG === want) found = 1'b1;
            else tick();
        end
        chk({tag, "_found"}, {31'd0, found}, 32'd1);
        if (found) chk(tag, {25'd0, SEG}, {25'd0, exp});
    endtask

    // Capture edge = edge 1; BUSY high through edge 8; result on edge 9.
    task automatic run_conv(input logic [7:0] s, input logic ov,
                            input logic [11:0] exp, input string tag);
        S = s; OV = ov; VLD = 1'b1;
        tick();
        VLD = 1'b0;
        chk({tag, "_busy1"}, {31'd0, BUSY}, 32'd1);
        chk({tag, "_rdy0"},  {31'd0, RDY},  32'd0);
        for (int e = 2; e <= 8; e++) begin
            tick();
            chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        end
        tick();
        chk({tag, "_busy_end"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_rdy"},      {31'd0, RDY},  32'd1);
        chk({tag, "_bcd"},      {20'd0, BCD},  {20'd0, exp});
        tick();
        tick();
    endtask

    initial begin
        logic [3:0] exp4, exp1;

        // ---------------- reset ----------------
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_bcd",  {20'd0, BCD}, 32'h000);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_rdy",  {31'd0, RDY}, 32'd0);
        chk("rst_dig",  {28'd0, DIG}, 32'b1110);
        chk("rst_seg",  {25'd0, SEG}, 32'b1000000);
        chk("rst_dig1", {28'd0, DIG1}, 32'b1110);

        // Scan timing: after edge n past reset, digit (n-1)/4 for SCAN_DIV=4
        // and (n-1)%4 for SCAN_DIV=1.
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp4 = ~(4'b0001 << (((n - 1) / 4) % 4));
            exp1 = ~(4'b0001 << ((n - 1) % 4));
            chk("scan4_dig", {28'd0, DIG},  {28'd0, exp4});
            chk("scan1_dig", {28'd0, DIG1}, {28'd0, exp1});
            chk("idle_bcd",  {20'd0, BCD},  32'h000);
            chk("idle_busy", {31'd0, BUSY}, 32'd0);
            chk("idle_rdy",  {31'd0, RDY},  32'd0);
        end

        // ---------------- max value ----------------
        run_conv(8'hFF, 1'b0, 12'h255, "ff");
        chk("ff_bcd1", {20'd0, BCD1}, 32'h255);
        chk_digit(0, 7'b0010010, "ff_d0");
        chk_digit(1, 7'b0010010, "ff_d1");
        chk_digit(2, 7'b0100100, "ff_d2");
        chk_digit(3, 7'b1111111, "ff_d3");

        // ---------------- leading-zero blanking ----------------
        run_conv(8'h07, 1'b0, 12'h007, "h07");
        chk_digit(0, 7'b1111000, "h07_d0");
        chk_digit(1, 7'b1111111, "h07_d1");
        chk_digit(2, 7'b1111111, "h07_d2");
        chk_digit(3, 7'b1111111, "h07_d3");

        // ---------------- overflow ----------------
        run_conv(8'h2A, 1'b1, 12'h042, "ov");
        chk_digit(0, 7'b0100100, "ov_d0");
        chk_digit(1, 7'b0011001, "ov_d1");
        chk_digit(2, 7'b1111111, "ov_d2");
        chk_digit(3, 7'b0000110, "ov_d3");

        // ---------------- VLD ignored during conversion ----------------
        S = 8'd100; OV = 1'b0; VLD = 1'b1;
        tick();
        S = 8'd9;
        chk("ign_busy1", {31'd0, BUSY}, 32'd1);
        for (int e = 2; e <= 8; e++) begin
            tick();
            chk("ign_busy", {31'd0, BUSY}, 32'd1);
        end
        tick();
        VLD = 1'b0;
        chk("ign_bcd", {20'd0, BCD}, 32'h100);
        chk("ign_rdy", {31'd0, RDY}, 32'd1);
        tick();
        tick();
        chk_digit(0, 7'b1000000, "d100_d0");
        chk_digit(1, 7'b1000000, "d100_d1");
        chk_digit(2, 7'b1111001, "d100_d2");
        chk_digit(3, 7'b1111111, "d100_d3");

        // ---------------- reset mid-conversion ----------------
        S = 8'd100; VLD = 1'b1;
        tick();
        VLD = 1'b0;
        tick();
        tick();
        tick();
        chk("abt_busy_pre", {31'd0, BUSY}, 32'd1);
        chk("abt_bcd_pre",  {20'd0, BCD},  32'h100);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abt_bcd",  {20'd0, BCD},  32'h000);
        chk("abt_busy", {31'd0, BUSY}, 32'd0);
        chk("abt_rdy",  {31'd0, RDY},  32'd0);
        chk("abt_dig",  {28'd0, DIG},  32'b1110);
        chk("abt_seg",  {25'd0, SEG},  32'b1000000);
        for (int n = 0; n < 12; n++) tick();
        chk("abt_idle_busy", {31'd0, BUSY}, 32'd0);
        chk("abt_idle_bcd",  {20'd0, BCD},  32'h000);

        // Restart from IDLE after abort.
        run_conv(8'd9, 1'b0, 12'h009, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
